// File: rtl/port_demux_pkg.sv
// Shared types and constants for the port_demux stream demultiplexer.
package port_demux_pkg;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] port_sel_t;

  typedef enum port_sel_t {
    PORT_A = 2'd0,
    PORT_B = 2'd1,
    PORT_C = 2'd2,
    PORT_D = 2'd3
  } port_id_e;

  // One-hot decode of a port index.
  function automatic logic [NPORTS-1:0] sel_onehot(input port_sel_t sel);
    logic [NPORTS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/port_demux_fifo.sv
// Synchronous first-word-fall-through FIFO used as one output lane of port_demux.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module port_demux_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Status flags and qualified handshakes.
  always_comb begin
    full_o  = (count_q == CntW'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    head_o  = mem_q[rptr_q];
  end

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/port_demux.sv
// 1-to-NPORTS stream demultiplexer: one valid/ready input routed by in_sel_i into
// per-port FWFT FIFOs, each drained by its own valid/ready handshake.
// Optional per-port delivered-beat counters (cnt_o) are built when PORT_DEMUX_CNT_EN
// is defined.
module port_demux #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DEPTH  = 2
`ifdef PORT_DEMUX_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [WIDTH-1:0]            in_data_i,
  input  port_demux_pkg::port_sel_t   in_sel_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [NPORTS*WIDTH-1:0]     out_data_o,
  output logic [NPORTS-1:0]           out_valid_o,
  input  logic [NPORTS-1:0]           out_ready_i
`ifdef PORT_DEMUX_CNT_EN
  ,
  output logic [NPORTS*CNT_W-1:0]     cnt_o
`endif
);

  import port_demux_pkg::*;

  logic [NPORTS-1:0] full, empty, push, pop;

  // Input ready depends only on the addressed FIFO; a pop there this cycle does not help.
  always_comb begin
    in_ready_o = ~full[in_sel_i];
    push       = '0;
    if (in_valid_i && in_ready_o) begin
      push = sel_onehot(in_sel_i);
    end
    out_valid_o = ~empty;
    pop         = out_valid_o & out_ready_i;
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    port_demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[k]),
      .data_i  (in_data_i),
      .pop_i   (pop[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .head_o  (out_data_o[k*WIDTH +: WIDTH])
    );
  end

`ifdef PORT_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [NPORTS];

  // Delivered-beat counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NPORTS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (pop[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_port_demux.sv
// Self-checking bench for port_demux: directed routing, backpressure, ordering,
// random traffic against a per-port queue model, and mid-operation reset.
module tb_port_demux;
  import port_demux_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 16;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [W-1:0]      in_data;
  port_sel_t         in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [NP*W-1:0]   out_data;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready;
`ifdef PORT_DEMUX_CNT_EN
  logic [NP*CW-1:0]  cnt;
`endif

  always #5 clk = ~clk;

  port_demux #(
    .WIDTH  (W),
    .NPORTS (NP),
    .DEPTH  (D)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
`ifdef PORT_DEMUX_CNT_EN
    ,
    .cnt_o       (cnt)
`endif
  );

  // Reference model: one queue and one delivered count per port.
  logic [W-1:0]  mq [NP][$];
  logic [CW-1:0] mcnt [NP];
  int unsigned   pops [NP];
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NP; k++) begin
      mq[k].delete();
      mcnt[k] = '0;
      pops[k] = 0;
    end
  endtask

  // Drive one cycle of stimulus, check all outputs against the model, clock, update model.
  task automatic cycle(input logic v, input port_sel_t s, input logic [W-1:0] d,
                       input logic [NP-1:0] r);
    logic          exp_rdy;
    logic [NP-1:0] exp_vld;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (mq[s].size() < D);
    check("in_ready", in_ready, exp_rdy);
    for (int k = 0; k < NP; k++) exp_vld[k] = (mq[k].size() != 0);
    check("out_valid", out_valid, exp_vld);
    for (int k = 0; k < NP; k++) begin
      if (exp_vld[k]) check($sformatf("out_data[%0d]", k), out_data[k*W +: W], mq[k][0]);
`ifdef PORT_DEMUX_CNT_EN
      check($sformatf("cnt[%0d]", k), cnt[k*CW +: CW], mcnt[k]);
`endif
    end
    @(posedge clk);
    for (int k = 0; k < NP; k++) begin
      if (exp_vld[k] && r[k]) begin
        void'(mq[k].pop_front());
        mcnt[k] = mcnt[k] + 1'b1;
        pops[k]++;
      end
    end
    if (v && exp_rdy) mq[s].push_back(d);
    #1;
  endtask

  initial begin
    int unsigned   sent;
    int unsigned   guard;
    logic          acc;
    logic          v;
    port_sel_t     s;
    logic [NP-1:0] r;

    // 1: reset
    rst_ni    = 1'b0;
    in_valid  = 1'b0;
    in_sel    = PORT_A;
    in_data   = '0;
    out_ready = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_data", out_data, 32'h0);
`ifdef PORT_DEMUX_CNT_EN
    check("rst_cnt", cnt, 64'h0);
`endif
    rst_ni = 1'b1;
    for (int k = 0; k < NP; k++) begin
      in_sel = port_sel_t'(k);
      #1;
      check($sformatf("rst_ready[%0d]", k), in_ready, 1'b1);
    end

    // 2: routing
    cycle(1'b1, PORT_A, 8'h11, 4'b0000);
    check("route_vld_a", out_valid, 4'b0001);
    cycle(1'b1, PORT_B, 8'h22, 4'b0000);
    check("route_vld_b", out_valid, 4'b0011);
    cycle(1'b1, PORT_C, 8'h33, 4'b0000);
    check("route_vld_c", out_valid, 4'b0111);
    cycle(1'b1, PORT_D, 8'h44, 4'b0000);
    in_valid = 1'b0;
    #1;
    check("route_vld_d", out_valid, 4'b1111);
    check("route_data", out_data, 32'h44332211);
    cycle(1'b0, PORT_A, 8'h00, 4'b1111);
    cycle(1'b0, PORT_A, 8'h00, 4'b0000);

    // 3: backpressure on port C
    cycle(1'b1, PORT_C, 8'hA0, 4'b0000);
    cycle(1'b1, PORT_C, 8'hA1, 4'b0000);
    in_valid = 1'b1;
    in_sel   = PORT_C;
    #1;
    check("bp_stall", in_ready, 1'b0);
    in_sel = PORT_A;
    #1;
    check("bp_other", in_ready, 1'b1);
    cycle(1'b1, PORT_C, 8'hA2, 4'b0100);
    cycle(1'b1, PORT_C, 8'hA2, 4'b0000);
    check("bp_accept", out_data[2*W +: W], 8'hA1);
    repeat (3) cycle(1'b0, PORT_A, 8'h00, 4'b0100);
    check("bp_pops", pops[2], 4);

    // 4: ordering on port B with random backpressure
    pops[1] = 0;
    sent    = 0;
    guard   = 0;
    while ((sent < 8 || mq[1].size() != 0) && guard < 200) begin
      r   = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      acc = (sent < 8) && (mq[1].size() < D);
      cycle(sent < 8, PORT_B, W'(sent), r);
      if (acc) sent++;
      guard++;
    end
    check("ord_timeout", guard < 200, 1'b1);
    check("ord_pops", pops[1], 8);

    // 5: random traffic
    sent  = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      v   = ($urandom_range(0, 3) != 0);
      s   = port_sel_t'($urandom_range(0, 3));
      r   = NP'($urandom_range(0, 15));
      acc = v && (mq[s].size() < D);
      cycle(v, s, W'($urandom_range(0, 255)), r);
      if (acc) sent++;
      guard++;
    end
    check("rnd_timeout", guard < 20000, 1'b1);
    guard = 0;
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && guard < 20) begin
      cycle(1'b0, PORT_A, 8'h00, 4'b1111);
      guard++;
    end
    check("rnd_drain", guard < 20, 1'b1);
    cycle(1'b0, PORT_A, 8'h00, 4'b0000);

    // 6: mid-operation reset
    for (int k = 0; k < NP; k++) begin
      cycle(1'b1, port_sel_t'(k), 8'hC0 + 8'(k), 4'b0000);
      cycle(1'b1, port_sel_t'(k), 8'hD0 + 8'(k), 4'b0000);
    end
    in_valid = 1'b0;
    in_sel   = PORT_B;
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 4'b0000);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_ready", in_ready, 1'b1);
`ifdef PORT_DEMUX_CNT_EN
    check("mid_rst_cnt", cnt, 64'h0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (4) cycle(1'b0, PORT_A, 8'h00, 4'b1111);
    check("post_rst_pops", pops[0] + pops[1] + pops[2] + pops[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
